// File: rtl/sub64_pipe.sv
// sub64_pipe -- two-stage pipelined 64-bit subtractor, diff = a - b - Bin.
//
// The subtraction is split into two 32-bit halves. Stage 1 subtracts the low
// halves and registers the borrow between halves along with the upper operand
// halves. Stage 2 subtracts the upper halves using that registered borrow.
// Both stages use a valid/ready handshake that sustains one transfer per cycle
// and back-pressures when both stages are full and the consumer stalls.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand set a/b/Bin is valid this cycle
//   in_ready   block accepts operands this cycle
//   a, b       64-bit minuend / subtrahend
//   Bin        borrow-in
//   out_valid  result valid
//   out_ready  downstream accepts result
//   diff       a - b - Bin mod 2^64
//   Bout       borrow-out, 1 iff unsigned a < b + Bin
//   zero, neg, ovf  result flags (only when SUB_FLAGS_EN is defined)
//
// Configuration macro: SUB_FLAGS_EN -- adds the zero/neg/ovf flag ports and
// their stage-2 registers. Without it, diff, Bout and timing are unchanged.

module sub64_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        Bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] diff,
    output logic        Bout
`ifdef SUB_FLAGS_EN
    ,
    output logic        zero,
    output logic        neg,
    output logic        ovf
`endif
);

    // 32-bit half subtract as x + ~y + ~borrow_in; result is {borrow_out, diff}
    // where the borrow-out is the inverted carry-out.
    function automatic logic [32:0] sub32(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic        bin);
        logic [32:0] sum;
        sum = {1'b0, x} + {1'b0, ~y} + {32'd0, ~bin};
        return {~sum[32], sum[31:0]};
    endfunction

    logic        accept;
    logic        advance;
    logic [32:0] lo_res;
    logic [32:0] hi_res;

    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_lo_q, s1_lo_d;
    logic        s1_borrow_q, s1_borrow_d;
    logic [31:0] s1_ahi_q, s1_ahi_d;
    logic [31:0] s1_bhi_q, s1_bhi_d;

    logic        s2_valid_q, s2_valid_d;
    logic [63:0] diff_q, diff_d;
    logic        bout_q, bout_d;
`ifdef SUB_FLAGS_EN
    logic        zero_q, zero_d;
    logic        neg_q, neg_d;
    logic        ovf_q, ovf_d;
`endif

    // Stage 1 can always take new operands when it is empty or when it is
    // about to move into stage 2 (stage 2 empty or draining this cycle).
    assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign advance  = s1_valid_q && (!s2_valid_q || out_ready);

    assign lo_res = sub32(a[31:0], b[31:0], Bin);
    assign hi_res = sub32(s1_ahi_q, s1_bhi_q, s1_borrow_q);

    // ---- stage 1: low half and inter-half borrow ----
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_lo_d     = s1_lo_q;
        s1_borrow_d = s1_borrow_q;
        s1_ahi_d    = s1_ahi_q;
        s1_bhi_d    = s1_bhi_q;
        if (accept) begin
            s1_valid_d  = 1'b1;
            s1_lo_d     = lo_res[31:0];
            s1_borrow_d = lo_res[32];
            s1_ahi_d    = a[63:32];
            s1_bhi_d    = b[63:32];
        end else if (advance) begin
            s1_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
        end
    end

    // Operand payload needs no reset: it is only observed behind s1_valid_q.
    always_ff @(posedge clk) begin
        s1_lo_q     <= s1_lo_d;
        s1_borrow_q <= s1_borrow_d;
        s1_ahi_q    <= s1_ahi_d;
        s1_bhi_q    <= s1_bhi_d;
    end

    // ---- stage 2: high half, borrow-out and flags ----
    always_comb begin
        s2_valid_d = s2_valid_q;
        diff_d     = diff_q;
        bout_d     = bout_q;
`ifdef SUB_FLAGS_EN
        zero_d     = zero_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
`endif
        if (advance) begin
            s2_valid_d = 1'b1;
            diff_d     = {hi_res[31:0], s1_lo_q};
            bout_d     = hi_res[32];
`ifdef SUB_FLAGS_EN
            zero_d     = (hi_res[31:0] == 32'd0) && (s1_lo_q == 32'd0);
            neg_d      = hi_res[31];
            ovf_d      = (s1_ahi_q[31] != s1_bhi_q[31]) && (hi_res[31] != s1_ahi_q[31]);
`endif
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            diff_q     <= 64'd0;
            bout_q     <= 1'b0;
`ifdef SUB_FLAGS_EN
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            s2_valid_q <= s2_valid_d;
            diff_q     <= diff_d;
            bout_q     <= bout_d;
`ifdef SUB_FLAGS_EN
            zero_q     <= zero_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign out_valid = s2_valid_q;
    assign diff      = diff_q;
    assign Bout      = bout_q;
`ifdef SUB_FLAGS_EN
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_sub64_pipe.sv
// Testbench for sub64_pipe: directed vectors with hand-computed results,
// throughput/stall/reset scenarios and a randomized scoreboard run.
// Flag checks are compiled in when SUB_FLAGS_EN is defined.

module tb_sub64_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = 64'd0;
    logic [63:0] b = 64'd0;
    logic        Bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] diff;
    logic        Bout;
`ifdef SUB_FLAGS_EN
    logic        zero, neg, ovf;
`endif

    int nvec = 0;
    int nerr = 0;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        bin;
        logic [63:0] d;
        logic        bo;
        logic        z;
        logic        n;
        logic        o;
    } vec_t;

    typedef struct packed {
        logic [63:0] d;
        logic        bo;
        logic        z;
        logic        n;
        logic        o;
    } exp_t;

    // a, b, Bin -> diff, Bout, zero, neg, ovf (all hand-computed)
    vec_t dir_tab [0:7] = '{
        '{64'h10, 64'h3, 1'b0, 64'hD, 1'b0, 1'b0, 1'b0, 1'b0},
        '{64'h0, 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0},
        '{64'h1_0000_0000, 64'h0, 1'b1, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0},
        '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1},
        '{64'h5, 64'h5, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0},
        '{64'h0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0},
        '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0},
        '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1}
    };

    vec_t bb_tab [0:3] = '{
        '{64'd100, 64'd1, 1'b0, 64'd99, 1'b0, 1'b0, 1'b0, 1'b0},
        '{64'd200, 64'd50, 1'b1, 64'd149, 1'b0, 1'b0, 1'b0, 1'b0},
        '{64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0},
        '{64'd3, 64'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0}
    };

    vec_t st_tab [0:2] = '{
        '{64'h1000, 64'h1, 1'b0, 64'hFFF, 1'b0, 1'b0, 1'b0, 1'b0},
        '{64'h1, 64'h2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0},
        '{64'hFFFF_FFFF_0000_0000, 64'h1, 1'b0, 64'hFFFF_FFFE_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0}
    };

    sub64_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .Bout      (Bout)
`ifdef SUB_FLAGS_EN
        ,
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t ref_sub(input logic [63:0] x, input logic [63:0] y, input logic bi);
        logic [64:0] r;
        exp_t e;
        r    = {1'b0, x} - {1'b0, y} - {64'd0, bi};
        e.d  = r[63:0];
        e.bo = r[64];
        e.z  = (r[63:0] == 64'd0);
        e.n  = r[63];
        e.o  = (x[63] != y[63]) && (r[63] != x[63]);
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #2;
        nvec++;
        if ({out_valid, in_ready, Bout, diff} !== {1'b1 ^ 1'b1, 1'b1, 1'b0, 64'd0}) begin
            nerr++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b Bout=%b diff=%h, want 0 1 0 0",
                     out_valid, in_ready, Bout, diff);
        end
`ifdef SUB_FLAGS_EN
        nvec++;
        if ({zero, neg, ovf} !== 3'b000) begin
            nerr++;
            $display("FAIL reset_flags: got %b%b%b want 000", zero, neg, ovf);
        end
`endif
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        nvec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            nerr++;
            $display("FAIL reset_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_directed();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            a = dir_tab[i].a; b = dir_tab[i].b; Bin = dir_tab[i].bin;
            #1;
            nvec++;
            if (in_ready !== 1'b1) begin
                nerr++;
                $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready);
            end
            tick();
            // no handshake: these values must be ignored
            in_valid = 1'b0;
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; Bin = 1'($urandom_range(1));
            #1;
            nvec++;
            if (out_valid !== 1'b0) begin
                nerr++;
                $display("FAIL dir%0d_latency1: out_valid=%b want 0", i, out_valid);
            end
            tick();
            nvec++;
            if ({out_valid, Bout, diff} !== {1'b1, dir_tab[i].bo, dir_tab[i].d}) begin
                nerr++;
                $display("FAIL dir%0d_result: out_valid=%b Bout=%b diff=%h want 1 %b %h (flags z%b n%b o%b)",
                         i, out_valid, Bout, diff, dir_tab[i].bo, dir_tab[i].d,
                         dir_tab[i].z, dir_tab[i].n, dir_tab[i].o);
            end
`ifdef SUB_FLAGS_EN
            nvec++;
            if ({zero, neg, ovf} !== {dir_tab[i].z, dir_tab[i].n, dir_tab[i].o}) begin
                nerr++;
                $display("FAIL dir%0d_flags: got %b%b%b want %b%b%b", i, zero, neg, ovf,
                         dir_tab[i].z, dir_tab[i].n, dir_tab[i].o);
            end
`endif
        end
        tick();
        nvec++;
        if (out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL dir_idle: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin
                in_valid = 1'b1;
                a = bb_tab[c].a; b = bb_tab[c].b; Bin = bb_tab[c].bin;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 2 || c > 5) begin
                nvec++;
                if (out_valid !== 1'b0) begin
                    nerr++;
                    $display("FAIL b2b_c%0d_idle: out_valid=%b want 0", c, out_valid);
                end
            end else begin
                nvec++;
                if ({out_valid, Bout, diff} !== {1'b1, bb_tab[c-2].bo, bb_tab[c-2].d}) begin
                    nerr++;
                    $display("FAIL b2b_c%0d_result: out_valid=%b Bout=%b diff=%h want 1 %b %h (flags z%b n%b o%b)",
                             c, out_valid, Bout, diff, bb_tab[c-2].bo, bb_tab[c-2].d,
                             bb_tab[c-2].z, bb_tab[c-2].n, bb_tab[c-2].o);
                end
`ifdef SUB_FLAGS_EN
                nvec++;
                if ({zero, neg, ovf} !== {bb_tab[c-2].z, bb_tab[c-2].n, bb_tab[c-2].o}) begin
                    nerr++;
                    $display("FAIL b2b_c%0d_flags: got %b%b%b", c, zero, neg, ovf);
                end
`endif
            end
            if (c < 4) begin
                nvec++;
                if (in_ready !== 1'b1) begin
                    nerr++;
                    $display("FAIL b2b_c%0d_in_ready: got %b want 1", c, in_ready);
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            a = st_tab[k].a; b = st_tab[k].b; Bin = st_tab[k].bin;
            #1;
            nvec++;
            if (in_ready !== 1'b1) begin
                nerr++;
                $display("FAIL stall_fill%0d_in_ready: got %b want 1", k, in_ready);
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            #1;
            nvec++;
            if ({in_ready, out_valid, Bout, diff} !== {1'b0, 1'b1, st_tab[0].bo, st_tab[0].d}) begin
                nerr++;
                $display("FAIL stall_hold%0d: in_ready=%b out_valid=%b Bout=%b diff=%h want 0 1 %b %h",
                         k, in_ready, out_valid, Bout, diff, st_tab[0].bo, st_tab[0].d);
            end
            tick();
        end
        a = st_tab[2].a; b = st_tab[2].b; Bin = st_tab[2].bin;
        out_ready = 1'b1;
        #1;
        nvec++;
        if ({in_ready, out_valid, diff} !== {1'b1, 1'b1, st_tab[0].d}) begin
            nerr++;
            $display("FAIL stall_release: in_ready=%b out_valid=%b diff=%h want 1 1 %h",
                     in_ready, out_valid, diff, st_tab[0].d);
        end
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 3; k++) begin
            #1;
            nvec++;
            if ({out_valid, Bout, diff} !== {1'b1, st_tab[k].bo, st_tab[k].d}) begin
                nerr++;
                $display("FAIL stall_drain%0d: out_valid=%b Bout=%b diff=%h want 1 %b %h (flags z%b n%b o%b)",
                         k, out_valid, Bout, diff, st_tab[k].bo, st_tab[k].d,
                         st_tab[k].z, st_tab[k].n, st_tab[k].o);
            end
`ifdef SUB_FLAGS_EN
            nvec++;
            if ({zero, neg, ovf} !== {st_tab[k].z, st_tab[k].n, st_tab[k].o}) begin
                nerr++;
                $display("FAIL stall_drain%0d_flags: got %b%b%b", k, zero, neg, ovf);
            end
`endif
            tick();
        end
        #1;
        nvec++;
        if (out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL stall_empty: out_valid=%b want 0", out_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; a = 64'd7; b = 64'd2; Bin = 1'b0;
        tick();
        a = 64'd9;
        tick();
        in_valid = 1'b0;
        #1;
        nvec++;
        if ({out_valid, in_ready} !== 2'b10) begin
            nerr++;
            $display("FAIL rstmid_full: out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({out_valid, in_ready, Bout, diff} !== {1'b0, 1'b1, 1'b0, 64'd0}) begin
            nerr++;
            $display("FAIL rstmid_async: out_valid=%b in_ready=%b Bout=%b diff=%h want 0 1 0 0",
                     out_valid, in_ready, Bout, diff);
        end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            nvec++;
            if ({out_valid, in_ready} !== 2'b01) begin
                nerr++;
                $display("FAIL rstmid_stale%0d: out_valid=%b in_ready=%b want 0 1", k, out_valid, in_ready);
            end
        end
        in_valid = 1'b1; a = 64'h10; b = 64'h3; Bin = 1'b0;
        tick();
        in_valid = 1'b0;
        #1;
        nvec++;
        if (out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL rstmid_first_lat: out_valid=%b want 0", out_valid);
        end
        tick();
        nvec++;
        if ({out_valid, Bout, diff} !== {1'b1, 1'b0, 64'hD}) begin
            nerr++;
            $display("FAIL rstmid_first: out_valid=%b Bout=%b diff=%h want 1 0 d", out_valid, Bout, diff);
        end
        tick();
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        int sent = 0;
        int recv = 0;
        int cyc = 0;
        while ((sent < 10000 || q.size() != 0) && cyc < 40000) begin
            in_valid = (sent < 10000) && ($urandom_range(3) != 0);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(5))
                0: b = a;
                1: a[31:0] = b[31:0];
                2: a = 64'd0;
                3: b = 64'hFFFF_FFFF_FFFF_FFFF;
                default: ;
            endcase
            Bin = 1'($urandom_range(1));
            out_ready = 1'($urandom_range(1));
            #1;
            nvec++;
            if (in_ready !== ((q.size() < 2) || out_ready)) begin
                nerr++;
                $display("FAIL rnd_in_ready cyc%0d: got %b inflight=%0d out_ready=%b",
                         cyc, in_ready, q.size(), out_ready);
            end
            if (out_valid && out_ready) begin
                nvec++;
                if (q.size() == 0) begin
                    nerr++;
                    $display("FAIL rnd_spurious cyc%0d: result diff=%h with nothing in flight", cyc, diff);
                end else begin
                    e = q.pop_front();
                    recv++;
                    if ({Bout, diff} !== {e.bo, e.d}) begin
                        nerr++;
                        $display("FAIL rnd_result%0d: Bout=%b diff=%h want %b %h (flags z%b n%b o%b)",
                                 recv, Bout, diff, e.bo, e.d, e.z, e.n, e.o);
                    end
`ifdef SUB_FLAGS_EN
                    nvec++;
                    if ({zero, neg, ovf} !== {e.z, e.n, e.o}) begin
                        nerr++;
                        $display("FAIL rnd_flags%0d: got %b%b%b want %b%b%b", recv,
                                 zero, neg, ovf, e.z, e.n, e.o);
                    end
`endif
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_sub(a, b, Bin));
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        nvec++;
        if (recv != 10000 || q.size() != 0) begin
            nerr++;
            $display("FAIL rnd_drain: received %0d of 10000, %0d left in flight", recv, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
